// File: rtl/irda_wb_slave.sv
// rtl/irda_wb_slave.sv - Wishbone classic slave front end for the IrDA register file.
// Optional byte-lane writes: define IRDA_WB_BYTE_SEL_EN.
module irda_wb_slave #(
    parameter int DW          = 32,
    parameter int AW          = 4,
    parameter int NREGS       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                wb_rst_i,
    input  logic [AW-1:0]       wb_adr_i,
    input  logic [DW-1:0]       wb_dat_i,
    input  logic [DW/8-1:0]     wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic [DW-1:0]       wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [NREGS-1:0]    reg_we_o,
    output logic [NREGS-1:0]    reg_re_o,
    output logic [DW/8-1:0]     reg_be_o,
    output logic [DW-1:0]       reg_wdata_o,
    input  logic [NREGS*DW-1:0] reg_rdata_i
);

    localparam int            SW      = DW / 8;
    localparam logic [3:0]    WS      = 4'(WAIT_STATES);
    localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req;
    logic              hit;
    logic              enter_resp;
    logic [NREGS-1:0]  addr_onehot;
    logic [DW-1:0]     rd_slice;
    logic [SW-1:0]     wr_lanes;

    // Lanes that actually take part in a write; an empty mask still terminates normally.
`ifdef IRDA_WB_BYTE_SEL_EN
    assign wr_lanes = wb_sel_i;
`else
    logic sel_unused;
    assign sel_unused = ^wb_sel_i;
    assign wr_lanes   = '1;
`endif

    assign req = wb_stb_i & wb_cyc_i;
    assign hit = ({1'b0, wb_adr_i} < NREGS_W);

    always_comb begin
        addr_onehot = '0;
        rd_slice    = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (wb_adr_i == AW'(k)) begin
                addr_onehot[k] = 1'b1;
                rd_slice       = reg_rdata_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A master that withdraws its strobe mid-wait abandons the transfer silently.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Terminations and strobes are registered on entry to RESP so they line up with ack.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            reg_we_o    <= '0;
            reg_re_o    <= '0;
            reg_be_o    <= '0;
            reg_wdata_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            reg_we_o <= '0;
            reg_re_o <= '0;
            reg_be_o <= '0;
            if (enter_resp) begin
                if (hit) begin
                    wb_ack_o <= 1'b1;
                    if (wb_we_i) begin
                        reg_wdata_o <= wb_dat_i;
                        if (|wr_lanes) begin
                            reg_we_o <= addr_onehot;
                            reg_be_o <= wr_lanes;
                        end
                    end else begin
                        reg_re_o <= addr_onehot;
                        wb_dat_o <= rd_slice;
                    end
                end else begin
                    wb_err_o <= 1'b1;
                    wb_dat_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_irda_wb_slave.sv
// tb/tb_irda_wb_slave.sv - directed self-checking bench for irda_wb_slave (0 and 3 wait states).
module tb_irda_wb_slave;

    logic         clk = 1'b0;
    logic         wb_rst_i;
    logic [3:0]   adr;
    logic [31:0]  dat_i;
    logic [3:0]   sel;
    logic         we, stb, cyc;
    logic [255:0] rdata;

    logic [31:0]  dat0, dat3, wd0, wd3;
    logic         ack0, ack3, err0, err3;
    logic [7:0]   we0, we3, re0, re3;
    logic [3:0]   be0, be3;

    int checks   = 0;
    int failures = 0;
    logic seen;

    always #5 clk = ~clk;

    irda_wb_slave #(.DW(32), .AW(4), .NREGS(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .wb_rst_i(wb_rst_i), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat0), .wb_ack_o(ack0),
        .wb_err_o(err0), .reg_we_o(we0), .reg_re_o(re0), .reg_be_o(be0),
        .reg_wdata_o(wd0), .reg_rdata_i(rdata)
    );

    irda_wb_slave #(.DW(32), .AW(4), .NREGS(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .wb_rst_i(wb_rst_i), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat3), .wb_ack_o(ack3),
        .wb_err_o(err3), .reg_we_o(we3), .reg_re_o(re3), .reg_be_o(be3),
        .reg_wdata_o(wd3), .reg_rdata_i(rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
    endtask

    task automatic present(input logic [3:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        adr   = a;
        dat_i = d;
        we    = w;
        sel   = s;
        stb   = 1'b1;
        cyc   = 1'b1;
    endtask

    task automatic watch_ws3(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | ack3 | err3 | (|re3) | (|we3);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        adr = '0; dat_i = '0; sel = '0;
        bus_idle();
        for (int k = 0; k < 8; k++) rdata[k*32 +: 32] = 32'h1000_0000 + k;
        rdata[5*32 +: 32] = 32'hDEAD_BEEF;

        @(negedge clk);
        tick();
        tick();
        wb_rst_i = 1'b0;
        tick();
        check_eq("reset_state_ws0", {dat0, ack0, err0, we0, re0, be0}, 64'h0);
        check_eq("reset_wdata_ws0", wd0, 32'h0);
        check_eq("reset_state_ws3", {dat3, ack3, err3, we3, re3, be3}, 64'h0);

        // Reset held two cycles under an active request
        present(4'd0, 32'h0, 1'b0, 4'hF);
        wb_rst_i = 1'b1;
        tick();
        check_eq("rst_req_c1", {ack0, err0, re0, we0, ack3}, 64'h0);
        tick();
        check_eq("rst_req_c2", {ack0, err0, re0, we0, dat0}, 64'h0);
        wb_rst_i = 1'b0;
        bus_idle();
        tick();
        tick();
        tick();
        check_eq("rst_no_late_ack", {ack0, ack3, err0, err3}, 64'h0);

        // Zero wait states: write 0xA5A5_1234 to address 3
        present(4'd3, 32'hA5A5_1234, 1'b1, 4'hF);
        tick();
        check_eq("w0_ack", {ack0, err0}, 64'h2);
        check_eq("w0_we", we0, 64'h08);
        check_eq("w0_wdata", wd0, 64'hA5A5_1234);
        check_eq("w0_be", be0, 64'hF);
        check_eq("w0_re", re0, 64'h0);
        bus_idle();
        tick();
        check_eq("w0_c2_ack_low", {ack0, we0, be0}, 64'h0);
        check_eq("w0_wdata_hold", wd0, 64'hA5A5_1234);
        tick();
        check_eq("w0_ws3_aborted", {ack3, we3, wd3}, 64'h0);

        // Three wait states: read address 5, and back-to-back acks on the zero-wait instance
        present(4'd5, 32'h0, 1'b0, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("r3_ack3_c%0d", c), ack3, (c == 4) ? 64'h1 : 64'h0);
            check_eq($sformatf("r3_ack0_c%0d", c), ack0, (c == 1 || c == 3) ? 64'h1 : 64'h0);
            if (c == 1) begin
                check_eq("r0_data", dat0, 64'hDEAD_BEEF);
                check_eq("r0_re", re0, 64'h20);
            end
        end
        check_eq("r3_data", dat3, 64'hDEAD_BEEF);
        check_eq("r3_re", re3, 64'h20);
        check_eq("r3_no_err_we", {err3, we3}, 64'h0);
        bus_idle();
        tick();
        check_eq("r3_after", {ack3, re3}, 64'h0);
        check_eq("r3_data_hold", dat3, 64'hDEAD_BEEF);

        // Unmapped read on the zero-wait instance
        present(4'd9, 32'h0, 1'b0, 4'hF);
        tick();
        check_eq("miss_r_err", {err0, ack0}, 64'h2);
        check_eq("miss_r_data", dat0, 64'h0);
        check_eq("miss_r_strobes", {we0, re0}, 64'h0);
        bus_idle();
        tick();
        check_eq("miss_r_err_low", err0, 64'h0);
        tick();

        // Unmapped write on the three-wait instance
        present(4'd12, 32'h1234_5678, 1'b1, 4'hF);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("miss_w3_err_c%0d", c), err3, (c == 4) ? 64'h1 : 64'h0);
        end
        check_eq("miss_w3_quiet", {ack3, we3, re3, dat3}, 64'h0);
        bus_idle();
        tick();

        // Strobe withdrawn after two cycles while waiting
        seen = 1'b0;
        present(4'd2, 32'h0, 1'b0, 4'hF);
        watch_ws3(2);
        bus_idle();
        watch_ws3(6);
        check_eq("abort_ws3_quiet", seen, 64'h0);

        // Reset in the middle of a waited write
        seen = 1'b0;
        present(4'd6, 32'hCAFE_F00D, 1'b1, 4'hF);
        watch_ws3(2);
        wb_rst_i = 1'b1;
        watch_ws3(1);
        wb_rst_i = 1'b0;
        bus_idle();
        watch_ws3(5);
        check_eq("rst_mid_ws3_quiet", seen, 64'h0);
        check_eq("rst_mid_ws3_wdata", wd3, 64'h0);

        // Byte-lane handling
        present(4'd1, 32'h1122_3344, 1'b1, 4'b0101);
        tick();
`ifdef IRDA_WB_BYTE_SEL_EN
        check_eq("sel_be", be0, 64'h5);
`else
        check_eq("sel_be", be0, 64'hF);
`endif
        check_eq("sel_we", we0, 64'h02);
        check_eq("sel_ack", ack0, 64'h1);
        bus_idle();
        tick();
        tick();

        present(4'd2, 32'h5566_7788, 1'b1, 4'b0000);
        tick();
        check_eq("sel0_ack", ack0, 64'h1);
`ifdef IRDA_WB_BYTE_SEL_EN
        check_eq("sel0_we", we0, 64'h00);
        check_eq("sel0_be", be0, 64'h0);
`else
        check_eq("sel0_we", we0, 64'h04);
        check_eq("sel0_be", be0, 64'hF);
`endif
        bus_idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
